// File: rtl/ps2_pointer_decoder.sv
// Receive-only PS/2 pointer decoder: synchronizes and filters the device clock,
// frames 11-bit bytes, assembles 3-byte packets into sign-magnitude screen deltas.
module ps2_pointer_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       pointer_ready,
    output logic [8:0] pointer_delta_x,
    output logic [8:0] pointer_delta_y,
    output logic       pointer_select,
    output logic       frame_error
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} byteState_t;

    logic [1:0]    clkSync_q, dataSync_q;
    logic          filtClk_q, filtClk_d;
    logic [FW-1:0] filtCnt_q, filtCnt_d;
    logic [TW-1:0] timeCnt_q;
    byteState_t    state_q;
    logic [2:0]    bitCnt_q;
    logic [7:0]    shift_q, status_q, xByte_q;
    logic          parity_q, prevLeft_q;
    logic [1:0]    idx_q;
    logic          strobe, sampledData, byteOk, expired, busy;
    logic [7:0]    xMag_d, yMag_d;

    function automatic logic [7:0] magOf(input logic sign, input logic [7:0] low, input logic ovf);
        logic [8:0] v;
        logic [8:0] a;
        v = {sign, low};
        a = sign ? (~v + 9'd1) : v;
        if (ovf || a[8]) return 8'hFF;
        return a[7:0];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk};
            dataSync_q <= {dataSync_q[0], ps2_data};
        end
    end

    // The filtered clock flips only on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filtClk_d = filtClk_q;
        filtCnt_d = '0;
        if (clkSync_q[1] != filtClk_q) begin
            if (filtCnt_q == FW'(FILTER_LEN - 1)) filtClk_d = clkSync_q[1];
            else filtCnt_d = filtCnt_q + 1'b1;
        end
    end

    assign strobe      = filtClk_q & ~filtClk_d;
    assign sampledData = dataSync_q[1];
    assign byteOk      = (^{shift_q, parity_q}) & sampledData;
    assign expired     = (timeCnt_q == TW'(TIMEOUT_CYCLES));
    assign busy        = (state_q != IDLE) || (idx_q != 2'd0);
    assign xMag_d      = magOf(status_q[4], xByte_q, status_q[6]);
    assign yMag_d      = magOf(status_q[5], shift_q, status_q[7]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filtClk_q <= 1'b1;
            filtCnt_q <= '0;
            timeCnt_q <= '0;
        end else begin
            filtClk_q <= filtClk_d;
            filtCnt_q <= filtCnt_d;
            if (strobe) timeCnt_q <= '0;
            else if (!expired) timeCnt_q <= timeCnt_q + 1'b1;
        end
    end

    // Byte framing and packet assembly; a timeout abandons any partial work.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            bitCnt_q        <= '0;
            shift_q         <= '0;
            parity_q        <= 1'b0;
            status_q        <= '0;
            xByte_q         <= '0;
            idx_q           <= '0;
            prevLeft_q      <= 1'b0;
            pointer_ready   <= 1'b0;
            pointer_select  <= 1'b0;
            frame_error     <= 1'b0;
            pointer_delta_x <= '0;
            pointer_delta_y <= '0;
        end else begin
            pointer_ready  <= 1'b0;
            pointer_select <= 1'b0;
            frame_error    <= 1'b0;
            if (expired && busy) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else if (strobe) begin
                case (state_q)
                    IDLE: begin
                        if (!sampledData) begin
                            state_q  <= DATA;
                            bitCnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q  <= {sampledData, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 1'b1;
                        if (bitCnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        parity_q <= sampledData;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!byteOk) begin
                            frame_error <= 1'b1;
                            idx_q       <= '0;
                        end else begin
                            case (idx_q)
                                2'd0: begin
                                    if (shift_q[3]) begin
                                        status_q <= shift_q;
                                        idx_q    <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    xByte_q <= shift_q;
                                    idx_q   <= 2'd2;
                                end
                                default: begin
                                    // Device +Y is up; screen sign bit marks upward motion.
                                    pointer_delta_x <= {status_q[4] && (xMag_d != 8'd0), xMag_d};
                                    pointer_delta_y <= {!status_q[5] && (yMag_d != 8'd0), yMag_d};
                                    pointer_ready   <= 1'b1;
                                    pointer_select  <= status_q[0] & ~prevLeft_q;
                                    prevLeft_q      <= status_q[0];
                                    idx_q           <= '0;
                                end
                            endcase
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_pointer_decoder.sv
// Directed bench for ps2_pointer_decoder: drives PS/2 frames bit by bit and
// checks decoded packets, error pulses, timeout, glitch rejection and reset.
module tb_ps2_pointer_decoder;
    localparam int TIMEOUT = 2000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       pointer_ready, pointer_select, frame_error;
    logic [8:0] pointer_delta_x, pointer_delta_y;

    int testCount = 0;
    int failCount = 0;
    int readyCount = 0;
    int errCount = 0;
    int strayCount = 0;
    logic [8:0] capDx = '0, capDy = '0;
    logic       capSel = 1'b0;

    ps2_pointer_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .pointer_ready(pointer_ready),
        .pointer_delta_x(pointer_delta_x),
        .pointer_delta_y(pointer_delta_y),
        .pointer_select(pointer_select),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    // Pulses are counted per cycle, so a pulse longer than one cycle shows up as an extra count.
    always @(negedge clock) begin
        if (!reset) begin
            if (pointer_ready) begin
                readyCount++;
                capDx  = pointer_delta_x;
                capDy  = pointer_delta_y;
                capSel = pointer_select;
            end
            if (frame_error) errCount++;
            if (pointer_select && !pointer_ready) strayCount++;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic sendBit(input logic b);
        ps2_data = b;
        waitCycles(10);
        ps2_clk = 1'b0;
        waitCycles(20);
        ps2_clk = 1'b1;
        waitCycles(10);
    endtask

    task automatic sendByte(input logic [7:0] value, input logic badParity);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(value[i]);
        sendBit(~(^value) ^ badParity);
        sendBit(1'b1);
    endtask

    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        sendByte(b0, 1'b0);
        sendByte(b1, 1'b0);
        sendByte(b2, 1'b0);
        waitCycles(5);
    endtask

    task automatic checkPacket(input string tag, input int readyBefore,
                               input logic [8:0] expDx, input logic [8:0] expDy, input logic expSel);
        checkOutput({tag, "_ready"}, readyCount - readyBefore, 1);
        checkOutput({tag, "_dx"}, int'(capDx), int'(expDx));
        checkOutput({tag, "_dy"}, int'(capDy), int'(expDy));
        checkOutput({tag, "_sel"}, int'(capSel), int'(expSel));
    endtask

    initial begin
        int r0;
        int e0;

        waitCycles(3);
        checkOutput("rst_ready", int'(pointer_ready), 0);
        checkOutput("rst_dx", int'(pointer_delta_x), 0);
        checkOutput("rst_dy", int'(pointer_delta_y), 0);
        reset = 1'b0;
        waitCycles(20);

        r0 = readyCount;
        applyStimulus(8'h09, 8'h05, 8'h03);
        checkPacket("basic", r0, 9'h005, 9'h103, 1'b1);

        // Byte 0x01 lacks bit3 and must be silently dropped.
        r0 = readyCount;
        e0 = errCount;
        sendByte(8'h01, 1'b0);
        applyStimulus(8'h08, 8'h10, 8'h20);
        checkPacket("drop", r0, 9'h010, 9'h120, 1'b0);
        checkOutput("drop_err", errCount - e0, 0);

        r0 = readyCount;
        applyStimulus(8'h39, 8'hFB, 8'h00);
        checkPacket("sat", r0, 9'h105, 9'h0FF, 1'b1);
        r0 = readyCount;
        applyStimulus(8'h08, 8'h00, 8'h00);
        checkPacket("zero", r0, 9'h000, 9'h000, 1'b0);

        r0 = readyCount;
        e0 = errCount;
        sendByte(8'h09, 1'b1);
        waitCycles(5);
        checkOutput("par_err", errCount - e0, 1);
        checkOutput("par_noready", readyCount - r0, 0);
        applyStimulus(8'h09, 8'h05, 8'h03);
        checkPacket("after_err", r0, 9'h005, 9'h103, 1'b1);

        r0 = readyCount;
        applyStimulus(8'h48, 8'h01, 8'h00);
        checkPacket("ovf", r0, 9'h0FF, 9'h000, 1'b0);

        r0 = readyCount;
        e0 = errCount;
        sendByte(8'h09, 1'b0);
        sendByte(8'h07, 1'b0);
        waitCycles(TIMEOUT + 500);
        checkOutput("tmo_noready", readyCount - r0, 0);
        applyStimulus(8'h08, 8'h02, 8'hFE);
        checkPacket("tmo", r0, 9'h002, 9'h1FE, 1'b0);
        checkOutput("tmo_err", errCount - e0, 0);

        // Two-cycle low glitch with data low must not start a frame.
        r0 = readyCount;
        e0 = errCount;
        ps2_data = 1'b0;
        waitCycles(5);
        ps2_clk = 1'b0;
        waitCycles(2);
        ps2_clk = 1'b1;
        waitCycles(20);
        ps2_data = 1'b1;
        waitCycles(20);
        applyStimulus(8'h09, 8'h01, 8'h01);
        checkPacket("glitch", r0, 9'h001, 9'h101, 1'b1);
        checkOutput("glitch_err", errCount - e0, 0);

        sendByte(8'h08, 1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        reset = 1'b1;
        waitCycles(3);
        checkOutput("mid_rst_ready", int'(pointer_ready), 0);
        checkOutput("mid_rst_sel", int'(pointer_select), 0);
        checkOutput("mid_rst_ferr", int'(frame_error), 0);
        checkOutput("mid_rst_dx", int'(pointer_delta_x), 0);
        checkOutput("mid_rst_dy", int'(pointer_delta_y), 0);
        reset = 1'b0;
        waitCycles(20);
        r0 = readyCount;
        applyStimulus(8'h09, 8'h03, 8'h04);
        checkPacket("post_rst", r0, 9'h003, 9'h104, 1'b1);

        checkOutput("stray_select", strayCount, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
